// File: rtl/adc_frame_packer_if.sv
// Byte-wide valid/ready stream from the frame packer to the serial transmitter.
interface adc_frame_packer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/adc_frame_packer.sv
// Packs two-channel ADC results into header/seq/ch1/ch2 byte frames with a one-deep pending buffer.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte to every frame.
//
// state | meaning
// IDLE  | no frame active, waiting for a rising edge on complete
// SEND  | streaming the active frame, byte index idx_q
module adc_frame_packer #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  complete_i,
  input  logic [DATA_WIDTH-1:0] data_in_1_i,
  input  logic [DATA_WIDTH-1:0] data_in_2_i,
  input  logic                  clear_overrun_i,
  output logic                  frame_busy_o,
  output logic                  overrun_o,
  output logic [7:0]            drop_count_o,
  adc_frame_packer_if.master    tx
);
  localparam int unsigned NB        = DATA_WIDTH / 8;
  localparam int unsigned BASE_BITS = (2 + 2 * NB) * 8;
`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FL = 3 + 2 * NB;
`else
  localparam int unsigned FL = 2 + 2 * NB;
`endif
  localparam int unsigned   IW       = $clog2(FL);
  localparam logic [IW-1:0] LAST_IDX = IW'(FL - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic                  complete_q;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            seq_q, seq_d;
  logic [DATA_WIDTH-1:0] act1_q, act1_d, act2_q, act2_d;
  logic [DATA_WIDTH-1:0] pend1_q, pend1_d, pend2_q, pend2_d;
  logic                  pend_full_q, pend_full_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            drop_q, drop_d, drop_base;
  logic                  rise, accept, last_accept, drop;
  logic [BASE_BITS-1:0]  base_vec;
  logic [FL*8-1:0]       frame_vec;

  assign rise        = complete_i & ~complete_q;
  assign accept      = (state_q == SEND) & tx.tx_ready;
  assign last_accept = accept & (idx_q == LAST_IDX);

  // seq_q only advances on the final accept, exactly when the next frame loads,
  // so it always equals the sequence number of the active frame.
  assign base_vec = {HEADER_BYTE, seq_q, act1_q, act2_q};

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < int'(BASE_BITS / 8); i++) csum = csum ^ base_vec[8*i +: 8];
  end
  assign frame_vec = {base_vec, csum};
`else
  assign frame_vec = base_vec;
`endif

  assign tx.tx_valid  = (state_q == SEND);
  assign tx.tx_data   = (state_q == SEND) ? frame_vec[(FL - 1 - 32'(idx_q)) * 8 +: 8] : 8'h00;
  assign frame_busy_o = (state_q == SEND);
  assign overrun_o    = overrun_q;
  assign drop_count_o = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      complete_q  <= 1'b0;
      idx_q       <= '0;
      seq_q       <= 8'h00;
      act1_q      <= '0;
      act2_q      <= '0;
      pend1_q     <= '0;
      pend2_q     <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      drop_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      complete_q  <= complete_i;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      act1_q      <= act1_d;
      act2_q      <= act2_d;
      pend1_q     <= pend1_d;
      pend2_q     <= pend2_d;
      pend_full_q <= pend_full_d;
      overrun_q   <= overrun_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    act1_d      = act1_q;
    act2_d      = act2_q;
    pend1_d     = pend1_q;
    pend2_d     = pend2_q;
    pend_full_d = pend_full_q;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          act1_d  = data_in_1_i;
          act2_d  = data_in_2_i;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept && !last_accept) idx_d = idx_q + 1'b1;
        if (last_accept) begin
          seq_d = seq_q + 8'd1;
          idx_d = '0;
          if (pend_full_q) begin
            act1_d = pend1_q;
            act2_d = pend2_q;
            if (rise) begin
              pend1_d = data_in_1_i;
              pend2_d = data_in_2_i;
            end else begin
              pend_full_d = 1'b0;
            end
          end else if (rise) begin
            act1_d = data_in_1_i;
            act2_d = data_in_2_i;
          end else begin
            state_d = IDLE;
          end
        end else if (rise) begin
          if (!pend_full_q) begin
            pend1_d     = data_in_1_i;
            pend2_d     = data_in_2_i;
            pend_full_d = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as clear_overrun_i wins over the clear.
  always_comb begin
    drop_base = clear_overrun_i ? 8'h00 : drop_q;
    overrun_d = overrun_q & ~clear_overrun_i;
    drop_d    = drop_base;
    if (drop) begin
      overrun_d = 1'b1;
      if (drop_base != 8'hFF) drop_d = drop_base + 8'd1;
    end
  end
endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
- Consumes the two-channel averaged results produced by the ADC acquisition stage when its `complete` pulse fires.
- Packs each result pair into a byte frame: header, sequence number, channel 1, channel 2, optional checksum.
- Streams the frame over a byte valid/ready interface to the downstream serial transmitter.
- Holds one pending result in a one-deep buffer, so a new conversion cycle can finish while the previous frame is still draining.

Parameters:
- DATA_WIDTH, 24, width of each channel result; must be a multiple of 8. Bytes per channel NB = DATA_WIDTH/8.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- complete  input  1  result-ready level from acquisition stage; only its rising edge is used.
- data_in_1  input  DATA_WIDTH  channel 1 result, valid while complete=1.
- data_in_2  input  DATA_WIDTH  channel 2 result, valid while complete=1.
- tx_data  output  8  current frame byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  downstream accepts byte when tx_valid&tx_ready.
- frame_busy  output  1  high from frame load until its last byte is accepted.
- overrun  output  1  sticky; a result was dropped.
- drop_count  output  8  number of dropped results, saturates at 255.
- clear_overrun  input  1  synchronous clear of overrun and drop_count.

Behaviour:
- Reset values:
  - tx_data=0, tx_valid=0, frame_busy=0, overrun=0, drop_count=0.
  - Sequence counter=0, pending buffer empty, complete_r=0, state=IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no partial frame resumes.
- Edge detect:
  - complete_r is a register of complete.
  - edge = complete & ~complete_r.
  - data_in_1/2 are sampled on the clock where edge=1.
- Frame byte order (FL = 2+2·NB, plus 1 with the checksum option):
  - byte 0: HEADER_BYTE.
  - byte 1: seq.
  - channel 1 bytes, MSB first.
  - channel 2 bytes, MSB first.
- seq is assigned when a frame is loaded into the active registers. It increments by 1 after each frame's last byte is accepted and wraps 255→0. Dropped results consume no seq value.
- FSM states: IDLE, SEND.
  - IDLE: on edge, load the active registers and byte index=0, then go to SEND. tx_valid=1 and frame_busy=1 from the next cycle (latency 1 clock from the edge).
  - SEND: tx_data = byte[index]. tx_valid stays high and tx_data stays stable until accepted; this is the AXI-style rule.
    - On accept with index<FL-1: index+1.
    - On accept of the last byte: if pending is full, move pending to active, reset index to 0, stay in SEND; tx_valid stays high, so frames go back-to-back. Otherwise go to IDLE and drop tx_valid and frame_busy next cycle.
- Edge while in SEND:
  - Pending empty: store the result in pending.
  - Pending full: drop it, set overrun=1, and increment drop_count (saturating).
- Edge on the same cycle the last byte is accepted:
  - Pending empty: the new result loads directly into active and stays in SEND.
  - Pending full: pending goes to active and the new result goes to pending; nothing is dropped.
- If clear_overrun and a new drop occur in the same cycle, the set wins: overrun=1, drop_count=1.
- tx_ready is ignored while tx_valid=0.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- When defined: one extra byte is appended after channel 2. It is the XOR of all preceding frame bytes, header included. FL=9 for DATA_WIDTH=24.
- When undefined: there is no checksum byte, FL=8, and the XOR logic is not built.

Test Plan:
- Single frame, tx_ready=1, data_in_1=24'h123456, data_in_2=24'hABCDEF:
  - tx_valid rises 1 clk after the edge.
  - Bytes A5,00,12,34,56,AB,CD,EF on consecutive clocks.
  - With checksum enabled, a 9th byte of A5^00^12^34^56^AB^CD^EF.
  - frame_busy falls after the last byte.
- Backpressure: tx_ready toggled randomly → tx_data is stable while tx_valid&!tx_ready, and no byte is duplicated or lost.
- Pending: tx_ready=0, then 2 complete edges (values X, then Y), then tx_ready=1 → frame X (seq 0) then frame Y (seq 1) back-to-back, with tx_valid never low between them.
- Overrun: tx_ready=0, then 4 edges → overrun=1 and drop_count=2; clear_overrun pulse → both 0.
- Boundaries:
  - An edge on the last-byte-accept cycle yields a back-to-back frame.
  - 256 frames yield seq wrap 255→0.
  - Holding complete high for multiple cycles yields exactly one frame.
- Reset mid-frame at byte 3 → tx_valid=0 immediately (async). A subsequent edge yields a full frame starting at A5 with seq 00.
